// File: rtl/tumble_counter.sv
// rtl/tumble_counter.sv - Turing Tumble ripple-counter board: two dispensers, bit chain and landing tray
module tumble_counter #(
    parameter int unsigned N_BITS      = 5,
    parameter int unsigned TRAY_DEPTH  = 32,
    parameter int unsigned BLUE_COUNT  = 8,
    parameter int unsigned RED_COUNT   = 8,
    parameter int unsigned INIT_BITS   = 0,
    parameter int unsigned FIRST_COLOR = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                stopped,
    output logic [1:0]                          stop_cause,
    output logic [TRAY_DEPTH-1:0]               tray,
    output logic [$clog2(TRAY_DEPTH+1)-1:0]     tray_size,
    output logic [N_BITS-1:0]                   bits,
    output logic [$clog2(BLUE_COUNT+1)-1:0]     blue_left,
    output logic [$clog2(RED_COUNT+1)-1:0]      red_left
);

    localparam int TW = $clog2(TRAY_DEPTH + 1);
    localparam int BW = $clog2(BLUE_COUNT + 1);
    localparam int RW = $clog2(RED_COUNT + 1);
    localparam int PW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [N_BITS-1:0] INIT_V    = N_BITS'(INIT_BITS);
    localparam logic [BW-1:0]     BLUE_V    = BW'(BLUE_COUNT);
    localparam logic [RW-1:0]     RED_V     = RW'(RED_COUNT);
    localparam logic              FIRST_V   = FIRST_COLOR[0];
    localparam logic [PW-1:0]     LAST_POS  = PW'(N_BITS - 1);
    localparam logic [TW-1:0]     LAST_SLOT = TW'(TRAY_DEPTH - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BLUE = 2'b01;
    localparam logic [1:0] CAUSE_RED  = 2'b10;
    localparam logic [1:0] CAUSE_FULL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_ROLL,
        S_LAND,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [TRAY_DEPTH-1:0]   tray_q, tray_d;
    logic [TW-1:0]           tray_size_q, tray_size_d;
    logic [N_BITS-1:0]       bits_q, bits_d;
    logic [BW-1:0]           blue_q, blue_d;
    logic [RW-1:0]           red_q, red_d;
    logic                    req_q, req_d;
    logic                    color_q, color_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic [1:0]              cause_q, cause_d;

    // One-hot mask of the bit the marble currently sits on; avoids out-of-range selects.
    logic [N_BITS-1:0]       pos_mask;
    logic                    pos_bit;

    assign pos_mask = N_BITS'(1) << pos_q;
    assign pos_bit  = |(bits_q & pos_mask);

    always_comb begin
        state_d     = state_q;
        tray_d      = tray_q;
        tray_size_d = tray_size_q;
        bits_d      = bits_q;
        blue_d      = blue_q;
        red_d       = red_q;
        req_d       = req_q;
        color_d     = color_q;
        pos_d       = pos_q;
        cause_d     = cause_q;

        case (state_q)
            S_IDLE, S_STOP: begin
                if (start) begin
                    tray_d      = '0;
                    tray_size_d = '0;
                    bits_d      = INIT_V;
                    blue_d      = BLUE_V;
                    red_d       = RED_V;
                    req_d       = FIRST_V;
                    cause_d     = CAUSE_NONE;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!req_q && blue_q == '0) begin
                    cause_d = CAUSE_BLUE;
                    state_d = S_STOP;
                end else if (req_q && red_q == '0) begin
                    cause_d = CAUSE_RED;
                    state_d = S_STOP;
                end else begin
                    if (req_q) begin
                        red_d = red_q - RW'(1);
                    end else begin
                        blue_d = blue_q - BW'(1);
                    end
                    color_d = req_q;
                    pos_d   = '0;
                    state_d = S_ROLL;
                end
            end
            S_ROLL: begin
                if (!pos_bit) begin
                    bits_d  = bits_q | pos_mask;
                    req_d   = 1'b0;
                    state_d = S_LAND;
                end else begin
                    bits_d = bits_q & ~pos_mask;
                    if (pos_q == LAST_POS) begin
                        req_d   = 1'b1;
                        state_d = S_LAND;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end
            S_LAND: begin
                tray_d      = tray_q | (TRAY_DEPTH'(color_q) << tray_size_q);
                tray_size_d = tray_size_q + TW'(1);
                if (tray_size_q == LAST_SLOT) begin
                    cause_d = CAUSE_FULL;
                    state_d = S_STOP;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tray_q      <= '0;
            tray_size_q <= '0;
            bits_q      <= INIT_V;
            blue_q      <= BLUE_V;
            red_q       <= RED_V;
            req_q       <= FIRST_V;
            color_q     <= 1'b0;
            pos_q       <= '0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            tray_q      <= tray_d;
            tray_size_q <= tray_size_d;
            bits_q      <= bits_d;
            blue_q      <= blue_d;
            red_q       <= red_d;
            req_q       <= req_d;
            color_q     <= color_d;
            pos_q       <= pos_d;
            cause_q     <= cause_d;
        end
    end

    assign stopped    = (state_q == S_STOP);
    assign stop_cause = cause_q;
    assign tray       = tray_q;
    assign tray_size  = tray_size_q;
    assign bits       = bits_q;
    assign blue_left  = blue_q;
    assign red_left   = red_q;

endmodule

// File: tb/tb_tumble_counter.sv
// tb/tb_tumble_counter.sv - directed scoreboard bench for tumble_counter across four board configurations
module tb_tumble_counter;

    logic clk;
    logic rst;
    logic start_a, start_b, start_c, start_d;

    logic        stopped_a, stopped_b, stopped_c, stopped_d;
    logic [1:0]  cause_a, cause_b, cause_c, cause_d;
    logic [31:0] tray_a, tray_b, tray_c;
    logic [3:0]  tray_d;
    logic [5:0]  size_a, size_b, size_c;
    logic [2:0]  size_d;
    logic [4:0]  bits_a, bits_d;
    logic [1:0]  bits_b;
    logic [2:0]  bits_c;
    logic [3:0]  blue_a, blue_c, blue_d;
    logic [0:0]  blue_b;
    logic [3:0]  red_a, red_b, red_d;
    logic [1:0]  red_c;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_t;

    sb_t sb_q[$];

    tumble_counter u_a (
        .clk(clk), .rst(rst), .start(start_a), .stopped(stopped_a), .stop_cause(cause_a),
        .tray(tray_a), .tray_size(size_a), .bits(bits_a), .blue_left(blue_a), .red_left(red_a)
    );

    tumble_counter #(.N_BITS(2), .BLUE_COUNT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stopped(stopped_b), .stop_cause(cause_b),
        .tray(tray_b), .tray_size(size_b), .bits(bits_b), .blue_left(blue_b), .red_left(red_b)
    );

    tumble_counter #(.N_BITS(3), .BLUE_COUNT(8), .RED_COUNT(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .stopped(stopped_c), .stop_cause(cause_c),
        .tray(tray_c), .tray_size(size_c), .bits(bits_c), .blue_left(blue_c), .red_left(red_c)
    );

    tumble_counter #(.TRAY_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .stopped(stopped_d), .stop_cause(cause_d),
        .tray(tray_d), .tray_size(size_d), .bits(bits_d), .blue_left(blue_d), .red_left(red_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic chk_pop(input logic [63:0] obs);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fails++;
            $error("FAIL scoreboard_empty observed=%0h required=an entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fails++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic get_stop(input int sel);
        case (sel)
            0: return stopped_a;
            1: return stopped_b;
            2: return stopped_c;
            default: return stopped_d;
        endcase
    endfunction

    task automatic wait_stop(input int sel, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (get_stop(sel)) break;
            tick();
        end
        exp_push(tag, 64'd1);
        chk_pop(64'(get_stop(sel)));
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset then idle for 20 cycles
        exp_push("idle_stopped", 64'd0);
        exp_push("idle_size",    64'd0);
        exp_push("idle_bits",    64'd0);
        exp_push("idle_blue",    64'd8);
        exp_push("idle_red",     64'd8);
        exp_push("idle_cause",   64'd0);
        exp_push("idle_tray",    64'd0);
        repeat (20) tick();
        chk_pop(64'(stopped_a));
        chk_pop(64'(size_a));
        chk_pop(64'(bits_a));
        chk_pop(64'(blue_a));
        chk_pop(64'(red_a));
        chk_pop(64'(cause_a));
        chk_pop(64'(tray_a));

        // Minimal run latency, N_BITS=2 with a single blue marble
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exp_push("min_e1_blue",    64'd0);
        exp_push("min_e2_bits",    64'd1);
        exp_push("min_e3_size",    64'd1);
        exp_push("min_e3_tray",    64'd0);
        exp_push("min_e3_stopped", 64'd0);
        exp_push("min_e4_stopped", 64'd1);
        exp_push("min_e4_cause",   64'd1);
        tick();
        chk_pop(64'(blue_b));
        tick();
        chk_pop(64'(bits_b));
        tick();
        chk_pop(64'(size_b));
        chk_pop(64'(tray_b));
        chk_pop(64'(stopped_b));
        tick();
        chk_pop(64'(stopped_b));
        chk_pop(64'(cause_b));

        // Overflow run: eight blues wrap the 3-bit counter, the red sets bit 0
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        wait_stop(2, "ovf_stopped");
        exp_push("ovf_cause", 64'd1);
        exp_push("ovf_size",  64'd9);
        exp_push("ovf_tray",  64'h100);
        exp_push("ovf_bits",  64'd1);
        exp_push("ovf_red",   64'd1);
        exp_push("ovf_blue",  64'd0);
        chk_pop(64'(cause_c));
        chk_pop(64'(size_c));
        chk_pop(64'(tray_c));
        chk_pop(64'(bits_c));
        chk_pop(64'(red_c));
        chk_pop(64'(blue_c));

        // Tray full at depth 4
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_stop(3, "full_stopped");
        repeat (5) tick();
        exp_push("full_cause", 64'd3);
        exp_push("full_size",  64'd4);
        exp_push("full_blue",  64'd4);
        exp_push("full_bits",  64'd4);
        exp_push("full_tray",  64'd0);
        chk_pop(64'(cause_d));
        chk_pop(64'(size_d));
        chk_pop(64'(blue_d));
        chk_pop(64'(bits_d));
        chk_pop(64'(tray_d));

        // Start pulsed during ROLL must be ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_push("mid_e1_blue", 64'd7);
        exp_push("mid_e2_bits", 64'd1);
        exp_push("mid_e2_blue", 64'd7);
        exp_push("mid_e3_size", 64'd1);
        exp_push("mid_e3_blue", 64'd7);
        tick();
        chk_pop(64'(blue_a));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_pop(64'(bits_a));
        chk_pop(64'(blue_a));
        tick();
        chk_pop(64'(size_a));
        chk_pop(64'(blue_a));

        wait_stop(0, "run_a_stopped");
        exp_push("run_a_cause", 64'd1);
        exp_push("run_a_size",  64'd8);
        exp_push("run_a_bits",  64'd8);
        exp_push("run_a_blue",  64'd0);
        chk_pop(64'(cause_a));
        chk_pop(64'(size_a));
        chk_pop(64'(bits_a));
        chk_pop(64'(blue_a));

        // Re-run from STOP
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_push("rerun_stopped", 64'd0);
        exp_push("rerun_size",    64'd0);
        exp_push("rerun_blue",    64'd8);
        exp_push("rerun_bits",    64'd0);
        exp_push("rerun_cause",   64'd0);
        chk_pop(64'(stopped_a));
        chk_pop(64'(size_a));
        chk_pop(64'(blue_a));
        chk_pop(64'(bits_a));
        chk_pop(64'(cause_a));

        // Fourth marble reaches bit 2 thirteen edges after the restart
        repeat (13) tick();
        exp_push("pre_rst_bits", 64'd0);
        exp_push("pre_rst_size", 64'd3);
        exp_push("pre_rst_blue", 64'd4);
        chk_pop(64'(bits_a));
        chk_pop(64'(size_a));
        chk_pop(64'(blue_a));

        rst = 1'b1;
        #1;
        exp_push("rst_size",    64'd0);
        exp_push("rst_blue",    64'd8);
        exp_push("rst_bits",    64'd0);
        exp_push("rst_stopped", 64'd0);
        chk_pop(64'(size_a));
        chk_pop(64'(blue_a));
        chk_pop(64'(bits_a));
        chk_pop(64'(stopped_a));
        tick();
        rst = 1'b0;

        // Fresh run after reset
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_push("fresh_e1_blue", 64'd7);
        exp_push("fresh_e2_bits", 64'd1);
        exp_push("fresh_e3_size", 64'd1);
        tick();
        chk_pop(64'(blue_a));
        tick();
        chk_pop(64'(bits_a));
        tick();
        chk_pop(64'(size_a));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tumble_counter.md
# tumble_counter

- Parametrised, clocked successor to the single-shot puzzle harness: a Turing Tumble ripple-counter board.
- Contains a blue and a red marble dispenser, a chain of `N_BITS` bit flip-flops, and a tray that logs the colour of every marble that lands.
- A `start` pulse launches a run. The run ends (`stopped`) when a requested dispenser is empty or the tray is full.
- Used as the reusable engine for counter-style puzzles; depth, counter width and marble supply come from parameters.

## Interface
- `N_BITS`, 5: number of bit flip-flops in the counter chain (≥1).
- `TRAY_DEPTH`, 32: maximum marbles the tray records (≥1).
- `BLUE_COUNT`, 8: blue marbles loaded at reset/start.
- `RED_COUNT`, 8: red marbles loaded at reset/start.
- `INIT_BITS`, 0: initial counter value (`N_BITS` wide; bit 0 is the first bit a marble meets).
- `FIRST_COLOR`, 0: colour requested by the first release of a run (0 blue, 1 red).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle launch pulse.
- `stopped`  out  1  high while in STOP.
- `stop_cause`  out  2  01 blue empty, 10 red empty, 11 tray full, 00 not stopped.
- `tray`  out  `TRAY_DEPTH`  `tray[k]` = colour of k-th landed marble (0 blue, 1 red); unused bits 0.
- `tray_size`  out  `$clog2(TRAY_DEPTH+1)`  marbles landed this run.
- `bits`  out  `N_BITS`  current counter flip-flop states.
- `blue_left`  out  `$clog2(BLUE_COUNT+1)`  blue marbles remaining.
- `red_left`  out  `$clog2(RED_COUNT+1)`  red marbles remaining.

## Operation
- Internal registers:
  - `req`: requested colour.
  - `color`: colour of the marble in flight.
  - `pos`: bit index, `$clog2(N_BITS)` wide, minimum 1 bit.
- Run initialisation (INIT):
  - Clears `tray` and `tray_size`.
  - Sets `bits` = `INIT_BITS`, `blue_left` = `BLUE_COUNT`, `red_left` = `RED_COUNT`, `req` = `FIRST_COLOR`, `stop_cause` = 00.
- State machine (IDLE, RELEASE, ROLL, LAND, STOP):
  - IDLE: if `start`, perform INIT → RELEASE; otherwise hold.
  - RELEASE: if the `req` dispenser is empty, → STOP with `stop_cause` 01 (blue) or 10 (red). Otherwise decrement that dispenser, set `color` = `req`, `pos` = 0, → ROLL.
  - ROLL, when `bits[pos]` = 0: set it to 1, `req` = blue, → LAND (set-exit pulls the blue lever).
  - ROLL, when `bits[pos]` = 1: clear it to 0 (carry).
    - If `pos` = `N_BITS`−1: `req` = red, → LAND (overflow pulls the red lever).
    - Otherwise `pos`+1 and stay in ROLL.
  - LAND: `tray[tray_size]` = `color`, `tray_size`+1. If the new size equals `TRAY_DEPTH`, → STOP with `stop_cause` 11; else → RELEASE.
  - STOP: `stopped` = 1. If `start`, perform INIT → RELEASE (re-run); otherwise hold.
- `start` is ignored in RELEASE, ROLL and LAND; a run cannot be restarted mid-flight.
- Counters never underflow or overflow: the empty check precedes the decrement, and the full check happens at LAND.
- The marble in flight is not counted in the tray until LAND.

## Timing
- Reset (async, immediate):
  - State IDLE, `stopped` 0, `stop_cause` 00, `tray` 0, `tray_size` 0.
  - `bits` = `INIT_BITS`, `blue_left` = `BLUE_COUNT`, `red_left` = `RED_COUNT`, `req` = `FIRST_COLOR`.
- All outputs are registered and change only on rising `clk` edges (or on reset).
- Marble cost: 1 RELEASE + (k+1) ROLL + 1 LAND cycles, where k is the index of the bit where it exits. Overflow costs `N_BITS` ROLL cycles.
- `start` sampled at edge E0 → RELEASE after E0. The empty check with its decrement lands at E1.
- `stopped` rises on the edge that leaves RELEASE or LAND into STOP. `stopped` and `stop_cause` update on the same edge.
- Reset asserted mid-run aborts immediately. The in-flight marble is discarded and everything returns to reset values.

## Test plan
- Reset then idle: `rst` pulse, no `start` for 20 cycles → `stopped`=0, `tray_size`=0, `bits`=`INIT_BITS`, `blue_left`=8, `red_left`=8.
- Minimal run latency: `N_BITS`=2, `BLUE_COUNT`=1, `start` at E0 → `blue_left`=0 after E1, `bits`=01 after E2, `tray_size`=1 and `tray[0]`=0 after E3, `stopped`=1 with `stop_cause`=01 after E4.
- Counter with overflow, `N_BITS`=3, `BLUE_COUNT`=8, `RED_COUNT`=2, `INIT_BITS`=0:
  - Marbles 1–7 set the counter to 111; marble 8 ripples to 000 and requests red.
  - The red marble sets bit 0 and requests blue, which is empty.
  - Result: `stopped`, `stop_cause`=01, `tray_size`=9, `tray`=9'b1_0000_0000, `bits`=001, `red_left`=1.
- Tray full: `TRAY_DEPTH`=4, counts 8/8 → `stop_cause`=11, `tray_size`=4, `blue_left`=4; no fifth release occurs.
- Start ignored mid-run, re-run from STOP:
  - `start` pulsed during ROLL → no change in state or counters.
  - `start` in STOP → INIT: `tray_size`=0, dispensers reloaded, `stopped` falls on the next edge.
- Reset mid-run: assert `rst` while in ROLL with `pos`=2 → all outputs return to reset values at once; `start` after release of `rst` behaves as a fresh run.
